// File: rtl/vgafb_fifo_pkg.sv
// rtl/vgafb_fifo_pkg.sv - shared pointer-width rule and Gray/binary helpers for the vgafb pixel FIFO
package vgafb_fifo_pkg;

  // Widest pointer supported (ADDR_WIDTH up to 10); callers zero-extend into it and cast back down.
  localparam int MAX_PTR_W = 11;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
    logic [MAX_PTR_W-1:0] bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/vgafb_sync2.sv
// rtl/vgafb_sync2.sv - two-flop bus synchroniser, async active-low reset to zero
module vgafb_sync2 #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage1;

  // Input must be Gray coded so each stage only ever sees a single-bit change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage1 <= '0;
      o_q      <= '0;
    end else begin
      r_stage1 <= i_d;
      o_q      <= r_stage1;
    end
  end

endmodule

// File: rtl/vgafb_fifo_rdctl.sv
// rtl/vgafb_fifo_rdctl.sv - read-domain pointer, address and flag controller for the vgafb pixel FIFO
module vgafb_fifo_rdctl
  import vgafb_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH          = 4,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH:0]   WrPtrGray_in,
  input  logic                  RdEn_in,
  output logic [ADDR_WIDTH-1:0] RdAddr_out,
  output logic [ADDR_WIDTH:0]   RdPtrGray_out,
  output logic                  Empty_out,
  output logic                  AlmostEmpty_out,
  output logic [ADDR_WIDTH:0]   Level_out,
  output logic                  Underflow_out
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(ALMOST_EMPTY_THRESH);

  logic [PTR_W-1:0] w_wsync2;
  logic [PTR_W-1:0] w_wbin;
  logic             w_rd_ok;
  logic [PTR_W-1:0] w_rd_bin_next;
  logic [PTR_W-1:0] w_rd_gray_next;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] r_rd_bin;

  vgafb_sync2 #(.WIDTH(PTR_W)) u_wptr_sync (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_d     (WrPtrGray_in),
    .o_q     (w_wsync2)
  );

  assign w_wbin         = PTR_W'(gray2bin(MAX_PTR_W'(w_wsync2)));
  assign w_rd_ok        = RdEn_in & ~Empty_out;
  assign w_rd_bin_next  = r_rd_bin + PTR_W'(w_rd_ok);
  assign w_rd_gray_next = PTR_W'(bin2gray(MAX_PTR_W'(w_rd_bin_next)));
  // Flags use the post-read pointer so a read of the last word raises Empty on the same edge.
  assign w_level_next   = w_wbin - w_rd_bin_next;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_bin        <= '0;
      RdAddr_out      <= '0;
      RdPtrGray_out   <= '0;
      Empty_out       <= 1'b1;
      AlmostEmpty_out <= 1'b1;
      Level_out       <= '0;
      Underflow_out   <= 1'b0;
    end else begin
      r_rd_bin        <= w_rd_bin_next;
      RdAddr_out      <= w_rd_bin_next[ADDR_WIDTH-1:0];
      RdPtrGray_out   <= w_rd_gray_next;
      Empty_out       <= (w_rd_gray_next == w_wsync2);
      AlmostEmpty_out <= (w_level_next <= AE_THRESH);
      Level_out       <= w_level_next;
      Underflow_out   <= RdEn_in & Empty_out;
    end
  end

endmodule

// File: tb/tb_vgafb_fifo_rdctl.sv
// tb/tb_vgafb_fifo_rdctl.sv - directed self-checking bench for vgafb_fifo_rdctl
module tb_vgafb_fifo_rdctl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [4:0] WrPtrGray_in;
  logic       RdEn_in;
  logic [3:0] RdAddr_out;
  logic [4:0] RdPtrGray_out;
  logic       Empty_out;
  logic       AlmostEmpty_out;
  logic [4:0] Level_out;
  logic       Underflow_out;

  int checks = 0;
  int errors = 0;

  vgafb_fifo_rdctl #(.ADDR_WIDTH(4), .ALMOST_EMPTY_THRESH(2)) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .WrPtrGray_in    (WrPtrGray_in),
    .RdEn_in         (RdEn_in),
    .RdAddr_out      (RdAddr_out),
    .RdPtrGray_out   (RdPtrGray_out),
    .Empty_out       (Empty_out),
    .AlmostEmpty_out (AlmostEmpty_out),
    .Level_out       (Level_out),
    .Underflow_out   (Underflow_out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(Empty_out), 32'd1);
    chk({tag, "_aempty"}, 32'(AlmostEmpty_out), 32'd1);
    chk({tag, "_level"}, 32'(Level_out), 32'd0);
    chk({tag, "_rdaddr"}, 32'(RdAddr_out), 32'd0);
    chk({tag, "_rdgray"}, 32'(RdPtrGray_out), 32'd0);
    chk({tag, "_uflow"}, 32'(Underflow_out), 32'd0);
  endtask

  task automatic do_reset();
    Rst_n        = 1'b0;
    RdEn_in      = 1'b0;
    WrPtrGray_in = 5'h00;
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [4:0] prev_gray;
    logic [4:0] exp_gray;
    logic [4:0] k5;
    logic [3:0] wrap_addr [4];
    wrap_addr[0] = 4'd15;
    wrap_addr[1] = 4'd0;
    wrap_addr[2] = 4'd1;
    wrap_addr[3] = 4'd2;

    // Reset held with a random write pointer, then released with it at zero
    Rst_n        = 1'b0;
    RdEn_in      = 1'b0;
    WrPtrGray_in = 5'($urandom);
    repeat (3) tick();
    chk_reset_vals("rst_hold");
    WrPtrGray_in = 5'h00;
    Rst_n = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst_rel");

    // Single word: flags follow after the third edge
    WrPtrGray_in = 5'h01;
    tick();
    chk("sw_e1_empty", 32'(Empty_out), 32'd1);
    tick();
    chk("sw_e2_empty", 32'(Empty_out), 32'd1);
    tick();
    chk("sw_e3_empty", 32'(Empty_out), 32'd0);
    chk("sw_e3_level", 32'(Level_out), 32'd1);
    chk("sw_e3_aempty", 32'(AlmostEmpty_out), 32'd1);
    RdEn_in = 1'b1;
    tick();
    RdEn_in = 1'b0;
    chk("sw_rd_addr", 32'(RdAddr_out), 32'd1);
    chk("sw_rd_gray", 32'(RdPtrGray_out), 32'h01);
    chk("sw_rd_empty", 32'(Empty_out), 32'd1);
    chk("sw_rd_level", 32'(Level_out), 32'd0);
    chk("sw_rd_uflow", 32'(Underflow_out), 32'd0);

    // Full drain from level 16
    do_reset();
    WrPtrGray_in = 5'h18;
    repeat (3) tick();
    chk("fd_level16", 32'(Level_out), 32'd16);
    chk("fd_aempty16", 32'(AlmostEmpty_out), 32'd0);
    chk("fd_empty16", 32'(Empty_out), 32'd0);
    prev_gray = RdPtrGray_out;
    for (int k = 1; k <= 16; k++) begin
      RdEn_in = 1'b1;
      tick();
      k5 = 5'(k);
      exp_gray = k5 ^ (k5 >> 1);
      chk($sformatf("fd_gray_%0d", k), 32'(RdPtrGray_out), 32'(exp_gray));
      chk($sformatf("fd_onebit_%0d", k), 32'($countones(prev_gray ^ RdPtrGray_out)), 32'd1);
      chk($sformatf("fd_level_%0d", k), 32'(Level_out), 32'(16 - k));
      chk($sformatf("fd_aempty_%0d", k), 32'(AlmostEmpty_out), (16 - k <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("fd_empty_%0d", k), 32'(Empty_out), (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("fd_uflow_%0d", k), 32'(Underflow_out), 32'd0);
      prev_gray = RdPtrGray_out;
    end

    // Underflow: two requests while empty
    RdEn_in = 1'b1;
    tick();
    chk("uf_pulse1", 32'(Underflow_out), 32'd1);
    chk("uf_addr1", 32'(RdAddr_out), 32'd0);
    chk("uf_gray1", 32'(RdPtrGray_out), 32'h18);
    tick();
    chk("uf_pulse2", 32'(Underflow_out), 32'd1);
    RdEn_in = 1'b0;
    tick();
    chk("uf_clear", 32'(Underflow_out), 32'd0);
    chk("uf_addr3", 32'(RdAddr_out), 32'd0);
    chk("uf_gray3", 32'(RdPtrGray_out), 32'h18);

    // Wrap: advance read pointer to 30, then write pointer to 2 (next lap)
    WrPtrGray_in = 5'h11;
    repeat (3) tick();
    chk("wr_level14", 32'(Level_out), 32'd14);
    RdEn_in = 1'b1;
    repeat (14) tick();
    RdEn_in = 1'b0;
    chk("wr_pre_empty", 32'(Empty_out), 32'd1);
    chk("wr_pre_addr", 32'(RdAddr_out), 32'd14);
    chk("wr_pre_gray", 32'(RdPtrGray_out), 32'h11);
    chk("wr_pre_uflow", 32'(Underflow_out), 32'd0);
    WrPtrGray_in = 5'h03;
    repeat (3) tick();
    chk("wr_level4", 32'(Level_out), 32'd4);
    chk("wr_empty4", 32'(Empty_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      RdEn_in = 1'b1;
      tick();
      chk($sformatf("wr_addr_%0d", k), 32'(RdAddr_out), 32'(wrap_addr[k]));
      chk($sformatf("wr_level_%0d", k), 32'(Level_out), 32'(3 - k));
    end
    RdEn_in = 1'b0;
    chk("wr_end_empty", 32'(Empty_out), 32'd1);
    chk("wr_end_gray", 32'(RdPtrGray_out), 32'h03);

    // Asynchronous reset in the middle of a read burst
    do_reset();
    WrPtrGray_in = 5'h0C;
    repeat (3) tick();
    chk("ar_level8", 32'(Level_out), 32'd8);
    RdEn_in = 1'b1;
    tick();
    tick();
    chk("ar_level6", 32'(Level_out), 32'd6);
    chk("ar_addr2", 32'(RdAddr_out), 32'd2);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_reset_vals("ar_async");
    RdEn_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
